// File: rtl/max7219_checker_pkg.sv
// Shared register map, per-device register record and word decode/readback helpers
// for the MAX7219 daisy-chain checker.
package max7219_checker_pkg;

   localparam logic [3:0] C_ADDR_NOOP      = 4'h0;
   localparam logic [3:0] C_ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] C_ADDR_DIGIT7    = 4'h8;
   localparam logic [3:0] C_ADDR_DECODE    = 4'h9;
   localparam logic [3:0] C_ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] C_ADDR_SCAN      = 4'hB;
   localparam logic [3:0] C_ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] C_ADDR_TEST      = 4'hF;

   typedef struct packed {
      logic [7:0][7:0] digit;
      logic [7:0]      decode;
      logic [3:0]      intensity;
      logic [2:0]      scan;
      logic            shutdown;
      logic            test;
   } t_max7219_regs;

   // Apply one 12-bit device word (addr in [11:8], data in [7:0]) to a register record.
   function automatic t_max7219_regs decode_word(input t_max7219_regs regs,
                                                 input logic [11:0]   word);
      t_max7219_regs r;
      logic [3:0]    addr;
      logic [7:0]    data;
      r    = regs;
      addr = word[11:8];
      data = word[7:0];
      case (addr)
         C_ADDR_DECODE:    r.decode    = data;
         C_ADDR_INTENSITY: r.intensity = data[3:0];
         C_ADDR_SCAN:      r.scan      = data[2:0];
         C_ADDR_SHUTDOWN:  r.shutdown  = data[0];
         C_ADDR_TEST:      r.test      = data[0];
         default: begin
            if (addr >= C_ADDR_DIGIT0 && addr <= C_ADDR_DIGIT7)
               r.digit[3'(addr - C_ADDR_DIGIT0)] = data;
         end
      endcase
      return r;
   endfunction

   function automatic logic [7:0] read_reg(input t_max7219_regs regs,
                                           input logic [3:0]    addr);
      logic [7:0] d;
      d = 8'h00;
      case (addr)
         C_ADDR_DECODE:    d = regs.decode;
         C_ADDR_INTENSITY: d = {4'h0, regs.intensity};
         C_ADDR_SCAN:      d = {5'h00, regs.scan};
         C_ADDR_SHUTDOWN:  d = {7'h00, regs.shutdown};
         C_ADDR_TEST:      d = {7'h00, regs.test};
         default: begin
            if (addr >= C_ADDR_DIGIT0 && addr <= C_ADDR_DIGIT7)
               d = regs.digit[3'(addr - C_ADDR_DIGIT0)];
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/max7219_matrix_checker_device.sv
// One emulated MAX7219: latches its 16-bit chain slice into the register file on the
// LOAD strobe.
module max7219_device_model
   import max7219_checker_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   i_word,
   input  logic          i_latch,
   output t_max7219_regs o_regs
);

   t_max7219_regs regs_q;
   // The top nibble of a MAX7219 word is don't-care.
   logic          unused_hi;

   assign unused_hi = ^i_word[15:12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         regs_q <= '0;
      else if (i_latch)
         regs_q <= decode_word(regs_q, i_word[11:0]);
   end

   assign o_regs = regs_q;

endmodule

// File: rtl/max7219_matrix_checker.sv
// Snooping checker for a chain of G_NB_MATRIX MAX7219 devices: shift chain, frame
// counters, readback mux. Define MAX7219_CHECKER_DISPLAY_EN for register/screen dumps.
module max7219_matrix_checker
   import max7219_checker_pkg::*;
#(
   parameter int G_NB_MATRIX = 8
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_max7219_clk,
   input  logic                   i_max7219_din,
   input  logic                   i_max7219_load,
   input  logic [7:0]             i_display_reg_matrix_n,
   input  logic [3:0]             i_rd_addr,
   input  logic                   i_display_screen_matrix,
   output logic [7:0]             o_rd_data,
   output logic [15:0]            o_load_cnt,
   output logic                   o_bit_err,
   output logic [G_NB_MATRIX-1:0] o_shutdown_n
);

   localparam int C_CHAIN_W = 16 * G_NB_MATRIX;

   logic                 sclk_p0, sclk_p1, din_p0, load_p0, load_p1;
   logic                 sclk_rise, load_rise, frame_bad;
   logic [C_CHAIN_W-1:0] chain_q, chain_next;
   logic [15:0]          bit_cnt_q, bit_cnt_next, load_cnt_q;
   logic                 bit_err_q;
   t_max7219_regs        dev_regs [G_NB_MATRIX];

   // Stage p0: bus sample; p1: previous sample for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         din_p0  <= 1'b0;
         load_p0 <= 1'b0;
         load_p1 <= 1'b0;
      end else begin
         sclk_p0 <= i_max7219_clk;
         sclk_p1 <= sclk_p0;
         din_p0  <= i_max7219_din;
         load_p0 <= i_max7219_load;
         load_p1 <= load_p0;
      end
   end

   assign sclk_rise = sclk_p0 & ~sclk_p1;
   assign load_rise = load_p0 & ~load_p1;

   // A coincident SCLK edge is folded in before the latch sees the chain.
   always_comb begin
      chain_next   = chain_q;
      bit_cnt_next = bit_cnt_q;
      if (sclk_rise) begin
         chain_next   = {chain_q[C_CHAIN_W-2:0], din_p0};
         bit_cnt_next = (bit_cnt_q == 16'hFFFF) ? bit_cnt_q : bit_cnt_q + 16'd1;
      end
      frame_bad = (bit_cnt_next == 16'd0) || (bit_cnt_next[3:0] != 4'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q    <= '0;
         bit_cnt_q  <= '0;
         load_cnt_q <= '0;
         bit_err_q  <= 1'b0;
      end else begin
         chain_q <= chain_next;
         if (load_rise) begin
            bit_cnt_q  <= '0;
            load_cnt_q <= load_cnt_q + 16'd1;
            bit_err_q  <= frame_bad;
         end else begin
            bit_cnt_q  <= bit_cnt_next;
            bit_err_q  <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < G_NB_MATRIX; k++) begin : g_dev
      max7219_device_model u_dev (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_word  (chain_next[16*k +: 16]),
         .i_latch (load_rise),
         .o_regs  (dev_regs[k])
      );
      assign o_shutdown_n[k] = dev_regs[k].shutdown;
   end

   always_comb begin
      o_rd_data = 8'h00;
      for (int k = 0; k < G_NB_MATRIX; k++) begin
         if (i_display_reg_matrix_n == 8'(k))
            o_rd_data = read_reg(dev_regs[k], i_rd_addr);
      end
   end

   assign o_load_cnt = load_cnt_q;
   assign o_bit_err  = bit_err_q;

`ifdef MAX7219_CHECKER_DISPLAY_EN
   logic [7:0] disp_idx_q;
   logic       screen_q;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_idx_q <= '0;
         screen_q   <= 1'b0;
      end else begin
         disp_idx_q <= i_display_reg_matrix_n;
         screen_q   <= i_display_screen_matrix;
         if (disp_idx_q != i_display_reg_matrix_n &&
             int'(i_display_reg_matrix_n) < G_NB_MATRIX) begin
            $display("max7219[%0d] digits=%h decode=%h intensity=%h scan=%h shutdown=%b test=%b",
                     i_display_reg_matrix_n,
                     dev_regs[i_display_reg_matrix_n].digit,
                     dev_regs[i_display_reg_matrix_n].decode,
                     dev_regs[i_display_reg_matrix_n].intensity,
                     dev_regs[i_display_reg_matrix_n].scan,
                     dev_regs[i_display_reg_matrix_n].shutdown,
                     dev_regs[i_display_reg_matrix_n].test);
         end
         // Leftmost column is the device farthest from DIN, bit 7 first.
         if (i_display_screen_matrix && !screen_q) begin
            for (int r = 0; r < 8; r++) begin
               for (int k = G_NB_MATRIX - 1; k >= 0; k--) begin
                  for (int c = 7; c >= 0; c--) begin
                     $write("%s", (dev_regs[k].test ||
                                   (dev_regs[k].shutdown && (3'(r) <= dev_regs[k].scan) &&
                                    dev_regs[k].digit[r][c])) ? "#" : ".");
                  end
               end
               $write("\n");
            end
         end
      end
   end
`else
   logic unused_screen;
   assign unused_screen = i_display_screen_matrix;
`endif

endmodule

// File: tb/tb_max7219_matrix_checker.sv
// Randomized scoreboard bench for max7219_matrix_checker against a frame-level model.
module tb_max7219_matrix_checker;

   localparam int N = 8;
   localparam int W = 16 * N;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         sclk = 1'b0, din = 1'b0, load = 1'b0, scr = 1'b0;
   logic [7:0]   rd_idx = '0;
   logic [3:0]   rd_addr = '0;
   logic [7:0]   rd_data;
   logic [15:0]  load_cnt;
   logic         bit_err;
   logic [N-1:0] shdn;

   max7219_matrix_checker #(.G_NB_MATRIX(N)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .i_max7219_clk           (sclk),
      .i_max7219_din           (din),
      .i_max7219_load          (load),
      .i_display_reg_matrix_n  (rd_idx),
      .i_rd_addr               (rd_addr),
      .i_display_screen_matrix (scr),
      .o_rd_data               (rd_data),
      .o_load_cnt              (load_cnt),
      .o_bit_err               (bit_err),
      .o_shutdown_n            (shdn)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cnt;
      bit           err;
      logic [N-1:0] shdn;
   } t_exp;

   t_exp       load_q[$];
   logic [7:0] rd_q[$];
   bit         rd_vld = 1'b0;
   int         checks = 0, errors = 0;

   // Reference model: whole chain as one wide number, registers as [device][address]
   logic [W-1:0] m_chain;
   int           m_bits, m_cnt;
   logic [7:0]   m_reg [N][16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_chain = '0;
      m_bits  = 0;
      m_cnt   = 0;
      for (int k = 0; k < N; k++)
         for (int a = 0; a < 16; a++)
            m_reg[k][a] = 8'h00;
   endtask

   function automatic logic [7:0] model_rd(input int idx, input int a);
      if (idx >= N || a == 0 || a == 13 || a == 14) return 8'h00;
      return m_reg[idx][a];
   endfunction

   task automatic send_bit(input logic b);
      din = b;
      tick(2);
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
      m_chain = (m_chain << 1) | W'(b);
      m_bits  = (m_bits < 65535) ? m_bits + 1 : 65535;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_load();
      t_exp       e;
      logic [15:0] w;
      int          a;
      logic [7:0]  d;
      for (int k = 0; k < N; k++) begin
         w = m_chain[16*k +: 16];
         a = int'(w[11:8]);
         d = w[7:0];
         if (a >= 1 && a <= 9) m_reg[k][a] = d;
         else if (a == 10)     m_reg[k][a] = d & 8'h0F;
         else if (a == 11)     m_reg[k][a] = d & 8'h07;
         else if (a == 12 || a == 15) m_reg[k][a] = d & 8'h01;
      end
      e.err = (m_bits == 0) || (m_bits % 16 != 0);
      m_cnt = (m_cnt + 1) % 65536;
      e.cnt = m_cnt;
      for (int k = 0; k < N; k++) e.shdn[k] = m_reg[k][12][0];
      m_bits = 0;
      load_q.push_back(e);
      tick(2);
      load = 1'b1;
      tick(3);
      load = 1'b0;
      tick(3);
   endtask

   task automatic rd_check(input int idx, input int a);
      rd_idx  = 8'(idx);
      rd_addr = 4'(a);
      rd_q.push_back(model_rd(idx, a));
      rd_vld = 1'b1;
      tick(1);
      rd_vld = 1'b0;
   endtask

   // Monitor: a change of the LOAD counter marks a latched frame
   int   prev_cnt = 0;
   t_exp mon_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cnt = 0;
      end else begin
         if (int'(load_cnt) != prev_cnt) begin
            prev_cnt = int'(load_cnt);
            if (load_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL load_event actual=%0d required=none", load_cnt);
            end else begin
               mon_e = load_q.pop_front();
               chk("load_cnt", 32'(load_cnt), 32'(mon_e.cnt));
               chk("bit_err", 32'(bit_err), 32'(mon_e.err));
               chk("shutdown_n", 32'(shdn), 32'(mon_e.shdn));
            end
         end else begin
            chk("bit_err_idle", 32'(bit_err), 32'd0);
         end
         if (rd_vld) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_event actual=%0h required=none", rd_data);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nw;
      logic [15:0] w;
      model_reset();
      tick(3);
      rst_n = 1'b1;
      tick(2);

      chk("reset_load_cnt", 32'(load_cnt), 32'd0);
      chk("reset_shutdown_n", 32'(shdn), 32'd0);
      chk("reset_bit_err", 32'(bit_err), 32'd0);
      for (int i = 0; i <= N; i++)
         for (int a = 0; a < 16; a++) rd_check(i, a);

      // Wake every device
      for (int i = 0; i < N; i++) send_word(16'h0C01);
      do_load();
      for (int i = 0; i < N; i++) rd_check(i, 12);

      // First word lands farthest from DIN
      send_word(16'h0155);
      for (int i = 0; i < N - 2; i++) send_word(16'h0000);
      send_word(16'h01AA);
      do_load();
      for (int i = 0; i < N; i++) rd_check(i, 1);

      // Framing errors: short frame, then empty frame
      for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
      do_load();
      do_load();

      // Overlong frame: the first word falls off the top
      send_word(16'h0A0F);
      for (int i = 0; i < N; i++) send_word(16'h0A03);
      do_load();
      for (int i = 0; i < N; i++) rd_check(i, 10);

      for (int it = 0; it < 12; it++) begin
         nw = $urandom_range(1, N + 1);
         for (int i = 0; i < nw; i++) begin
            w = 16'($urandom);
            send_word(w);
         end
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < int'($urandom_range(1, 15)); i++) send_bit(1'($urandom_range(0, 1)));
         do_load();
         for (int i = 0; i < 6; i++) rd_check($urandom_range(0, N + 1), $urandom_range(0, 15));
         rd_check(255, $urandom_range(1, 8));
      end

      // Reset in the middle of a frame
      for (int i = 0; i < 40; i++) send_bit(1'b1);
      rst_n = 1'b0;
      model_reset();
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("midreset_load_cnt", 32'(load_cnt), 32'd0);
      for (int i = 0; i < N; i++) send_word(16'h0F01);
      do_load();
      for (int i = 0; i < N; i++) rd_check(i, 15);

      for (int i = 0; i < 50 && (load_q.size() != 0 || rd_q.size() != 0); i++) tick(1);
      chk("drain_load_q", 32'(load_q.size()), 32'd0);
      chk("drain_rd_q", 32'(rd_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
